// File: rtl/shift_sched.sv
// shift_sched: sequencing controller for the LED shift register.
// Generates the shift strobe at a switch-selected rate, supports run, pause
// and single-step modes, tracks the lit position and shift direction
// (wrap-left or bounce), and requests the initial one-hot load.
//
// Ports:
//   clock        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_enable     1 = run continuously, 0 = pause
//   i_rate       prescaler limit select (R0..R3)
//   i_step       level input, each rising edge steps once while paused
//   i_bounce     1 = ping-pong direction, 0 = wrap left only
//   o_valid      one-cycle shift strobe
//   o_dir        0 = shift left (position increments), 1 = shift right
//   o_load       load request to the shift register
//   o_load_data  load value, one-hot LSB
//   o_pos        current lit position
//   o_state      FSM state encoding
//
// state  | meaning
// INIT   | one cycle after reset, load request still asserted
// RUN    | prescaler counting, strobe on each terminal count
// PAUSE  | prescaler held, waiting for enable or a step edge
// STEP   | single strobe issued, prescaler cleared
module shift_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int R0         = 3,
    parameter int R1         = 10,
    parameter int R2         = 100,
    parameter int R3         = 5000,
    parameter int NB_LED     = 4,
    localparam int POS_W     = (NB_LED > 1) ? $clog2(NB_LED) : 1
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_rate,
    input  logic              i_step,
    input  logic              i_bounce,
    output logic              o_valid,
    output logic              o_dir,
    output logic              o_load,
    output logic [NB_LED-1:0] o_load_data,
    output logic [POS_W-1:0]  o_pos,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(NB_LED - 1);
    localparam logic [NB_LED-1:0] LOAD_VAL = NB_LED'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  dir_q, dir_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  load_q, load_d;
    logic                  step_prev_q, step_prev_d;

    logic [DATA_WIDTH-1:0] limit;
    logic [DATA_WIDTH-1:0] limit_m1;
    logic                  tick;
    logic                  step_edge;
    logic [POS_W-1:0]      pos_next;

    always_comb begin
        case (i_rate)
            2'd0:    limit = DATA_WIDTH'(R0);
            2'd1:    limit = DATA_WIDTH'(R1);
            2'd2:    limit = DATA_WIDTH'(R2);
            default: limit = DATA_WIDTH'(R3);
        endcase
    end

    assign limit_m1  = limit - DATA_WIDTH'(1);
    // >= rather than == so a drop to a smaller limit mid-count ticks at once
    // instead of wrapping the whole counter.
    assign tick      = (cnt_q >= limit_m1);
    assign step_edge = i_step & ~step_prev_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        load_d      = 1'b0;
        step_prev_d = i_step;
        case (state_q)
            ST_INIT: begin
                state_d = i_enable ? ST_RUN : ST_PAUSE;
            end
            ST_RUN: begin
                // The count still advances on the edge that leaves RUN, so a
                // tick coinciding with enable falling keeps its strobe.
                if (tick) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DATA_WIDTH'(1);
                end
                if (!i_enable) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                    valid_d = 1'b1;
                end
            end
            ST_STEP: begin
                cnt_d   = '0;
                state_d = i_enable ? ST_RUN : ST_PAUSE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Position moves on the edge that ends the strobe, keeping o_pos in
    // step with what the shift register holds after that strobe.
    always_comb begin
        pos_d = pos_q;
        dir_d = i_bounce ? dir_q : 1'b0;
        if (!i_bounce || !dir_q) begin
            pos_next = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
        end else begin
            pos_next = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
        end
        if (valid_q) begin
            pos_d = pos_next;
            if (i_bounce) begin
                if (pos_next == POS_MAX) begin
                    dir_d = 1'b1;
                end else if (pos_next == '0) begin
                    dir_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            load_q      <= 1'b1;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            load_q      <= load_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_dir       = dir_q;
    assign o_load      = load_q;
    assign o_load_data = LOAD_VAL;
    assign o_pos       = pos_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched with R0..R3 = 3,5,7,9 and NB_LED = 4.
module tb_shift_sched;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_rate;
    logic       i_step;
    logic       i_bounce;
    logic       o_valid;
    logic       o_dir;
    logic       o_load;
    logic [3:0] o_load_data;
    logic [1:0] o_pos;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    shift_sched #(
        .DATA_WIDTH(32), .R0(3), .R1(5), .R2(7), .R3(9), .NB_LED(4)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_rate(i_rate), .i_step(i_step), .i_bounce(i_bounce),
        .o_valid(o_valid), .o_dir(o_dir), .o_load(o_load),
        .o_load_data(o_load_data), .o_pos(o_pos), .o_state(o_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        int exp_strb[$];
        int exp_pos[$];
        bit pos_due;
        int p;
        i_enable = 1'b1; i_rate = 2'd0; i_step = 1'b0; i_bounce = 1'b0;
        i_reset = 1'b0;
        #1 i_reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (o_load !== 1'b1) begin errors++; $display("FAIL reset_load: got %0d want 1", o_load); end
        checks++; if (o_load_data !== 4'b0001) begin errors++; $display("FAIL reset_load_data: got %b want 0001", o_load_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", o_valid); end
        checks++; if (o_pos !== 2'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", o_pos); end
        checks++; if (o_dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0d want 0", o_dir); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
        i_reset = 1'b0;
        #1;
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL init_state: got %0d want 0", o_state); end
        checks++; if (o_load !== 1'b1) begin errors++; $display("FAIL init_load: got %0d want 1", o_load); end
        @(negedge clock);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL run_entry_state: got %0d want 1", o_state); end
        checks++; if (o_load !== 1'b0) begin errors++; $display("FAIL run_entry_load: got %0d want 0", o_load); end
        exp_strb = '{3, 6, 9, 12};
        exp_pos  = '{1, 2, 3, 0};
        pos_due  = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clock);
            if (pos_due) begin
                p = exp_pos.pop_front();
                checks++; if (o_pos !== 2'(p)) begin errors++; $display("FAIL run_pos: cycle %0d got %0d want %0d", i, o_pos, p); end
                pos_due = 1'b0;
            end
            if (exp_strb.size() > 0 && exp_strb[0] == i) begin
                void'(exp_strb.pop_front());
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL run_strobe: cycle %0d got %0d want 1", i, o_valid); end
                else pos_due = 1'b1;
            end else if (o_valid === 1'b1) begin
                checks++; errors++; $display("FAIL run_strobe: cycle %0d got 1 want 0", i);
            end
        end
    endtask

    task automatic test_rate_change();
        int exp_strb[$];
        int exp_pos[$];
        bit pos_due;
        int p;
        i_rate   = 2'd3;
        exp_strb = '{6, 9, 12};
        exp_pos  = '{1, 2, 3};
        pos_due  = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clock);
            if (pos_due) begin
                p = exp_pos.pop_front();
                checks++; if (o_pos !== 2'(p)) begin errors++; $display("FAIL rate_pos: cycle %0d got %0d want %0d", j, o_pos, p); end
                pos_due = 1'b0;
            end
            if (exp_strb.size() > 0 && exp_strb[0] == j) begin
                void'(exp_strb.pop_front());
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rate_strobe: cycle %0d got %0d want 1", j, o_valid); end
                else pos_due = 1'b1;
            end else if (o_valid === 1'b1) begin
                checks++; errors++; $display("FAIL rate_strobe: cycle %0d got 1 want 0", j);
            end
            if (j == 5) i_rate = 2'd0;
        end
    endtask

    task automatic test_pause_resume();
        int exp_strb[$];
        int exp_pos[$];
        bit pos_due;
        int p;
        i_rate   = 2'd1;
        exp_strb = '{4, 29, 34};
        exp_pos  = '{0, 1, 2};
        pos_due  = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clock);
            if (pos_due) begin
                p = exp_pos.pop_front();
                checks++; if (o_pos !== 2'(p)) begin errors++; $display("FAIL pause_pos: cycle %0d got %0d want %0d", k, o_pos, p); end
                pos_due = 1'b0;
            end
            if (exp_strb.size() > 0 && exp_strb[0] == k) begin
                void'(exp_strb.pop_front());
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pause_strobe: cycle %0d got %0d want 1", k, o_valid); end
                else pos_due = 1'b1;
            end else if (o_valid === 1'b1) begin
                checks++; errors++; $display("FAIL pause_strobe: cycle %0d got 1 want 0", k);
            end
            if (k >= 6 && k <= 25) begin
                checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL pause_state: cycle %0d got %0d want 2", k, o_state); end
            end
            if (k == 26) begin
                checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d want 1", o_state); end
            end
            if (k == 5) i_enable = 1'b0;
            if (k == 25) i_enable = 1'b1;
        end
    endtask

    task automatic test_single_step();
        int n_valid;
        i_enable = 1'b0;
        @(negedge clock);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL step_pre_state: got %0d want 2", o_state); end
        i_step  = 1'b1;
        n_valid = 0;
        for (int m = 2; m <= 11; m++) begin
            @(negedge clock);
            if (o_valid === 1'b1) n_valid++;
            if (m == 2) begin
                checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL step_state: got %0d want 3", o_state); end
            end
            if (m == 3) begin
                checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL step_back_state: got %0d want 2", o_state); end
                checks++; if (o_pos !== 2'd3) begin errors++; $display("FAIL step_pos: got %0d want 3", o_pos); end
            end
        end
        checks++; if (n_valid != 1) begin errors++; $display("FAIL step_count: got %0d want 1", n_valid); end
        i_step = 1'b0;
        @(negedge clock);
        i_step = 1'b1; i_enable = 1'b1;
        @(negedge clock);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL step_vs_enable_state: got %0d want 1", o_state); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL step_vs_enable_valid: got %0d want 0", o_valid); end
        // STEP cleared the prescaler, so RUN from 0 with L=5 strobes on the 5th edge.
        for (int m = 14; m <= 19; m++) begin
            @(negedge clock);
            checks++; if (o_valid !== (m == 18)) begin errors++; $display("FAIL step_resume_strobe: cycle %0d got %0d want %0d", m, o_valid, (m == 18)); end
        end
        checks++; if (o_pos !== 2'd0) begin errors++; $display("FAIL step_resume_pos: got %0d want 0", o_pos); end
        i_step = 1'b0;
    endtask

    task automatic test_bounce();
        int exp_strb[$];
        int exp_pos[$];
        int exp_dir[$];
        bit pos_due;
        int p;
        int d;
        @(negedge clock);
        i_reset = 1'b1; i_enable = 1'b1; i_rate = 2'd0; i_bounce = 1'b1; i_step = 1'b0;
        @(negedge clock);
        i_reset = 1'b0;
        @(negedge clock);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL bounce_entry_state: got %0d want 1", o_state); end
        exp_strb = '{3, 6, 9, 12, 15, 18, 21, 24, 27, 30};
        exp_pos  = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
        exp_dir  = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        pos_due  = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clock);
            if (pos_due) begin
                p = exp_pos.pop_front();
                d = exp_dir.pop_front();
                checks++; if (o_pos !== 2'(p)) begin errors++; $display("FAIL bounce_pos: cycle %0d got %0d want %0d", i, o_pos, p); end
                checks++; if (o_dir !== 1'(d)) begin errors++; $display("FAIL bounce_dir: cycle %0d got %0d want %0d", i, o_dir, d); end
                pos_due = 1'b0;
            end
            if (exp_strb.size() > 0 && exp_strb[0] == i) begin
                void'(exp_strb.pop_front());
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bounce_strobe: cycle %0d got %0d want 1", i, o_valid); end
                else pos_due = 1'b1;
            end else if (o_valid === 1'b1) begin
                checks++; errors++; $display("FAIL bounce_strobe: cycle %0d got 1 want 0", i);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (2) @(negedge clock);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0d want 1", o_valid); end
        checks++; if (o_pos !== 2'd2) begin errors++; $display("FAIL pre_reset_pos: got %0d want 2", o_pos); end
        checks++; if (o_dir !== 1'b1) begin errors++; $display("FAIL pre_reset_dir: got %0d want 1", o_dir); end
        #2 i_reset = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0d want 0", o_valid); end
        checks++; if (o_pos !== 2'd0) begin errors++; $display("FAIL async_pos: got %0d want 0", o_pos); end
        checks++; if (o_dir !== 1'b0) begin errors++; $display("FAIL async_dir: got %0d want 0", o_dir); end
        checks++; if (o_load !== 1'b1) begin errors++; $display("FAIL async_load: got %0d want 1", o_load); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d want 0", o_state); end
    endtask

    task automatic test_bounce_clear();
        i_enable = 1'b0; i_bounce = 1'b1; i_step = 1'b0;
        @(negedge clock);
        i_reset = 1'b0;
        @(negedge clock);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL clear_pause_state: got %0d want 2", o_state); end
        for (int s = 1; s <= 3; s++) begin
            i_step = 1'b1;
            @(negedge clock);
            checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL clear_step_state: step %0d got %0d want 3", s, o_state); end
            i_step = 1'b0;
            @(negedge clock);
            checks++; if (o_pos !== 2'(s)) begin errors++; $display("FAIL clear_step_pos: step %0d got %0d want %0d", s, o_pos, s); end
            checks++; if (o_dir !== (s == 3)) begin errors++; $display("FAIL clear_step_dir: step %0d got %0d want %0d", s, o_dir, (s == 3)); end
        end
        i_bounce = 1'b0;
        @(negedge clock);
        checks++; if (o_dir !== 1'b0) begin errors++; $display("FAIL clear_dir: got %0d want 0", o_dir); end
        checks++; if (o_pos !== 2'd3) begin errors++; $display("FAIL clear_pos_hold: got %0d want 3", o_pos); end
        i_step = 1'b1;
        @(negedge clock);
        i_step = 1'b0;
        @(negedge clock);
        checks++; if (o_pos !== 2'd0) begin errors++; $display("FAIL wrap_pos: got %0d want 0", o_pos); end
        checks++; if (o_dir !== 1'b0) begin errors++; $display("FAIL wrap_dir: got %0d want 0", o_dir); end
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_pause_resume();
        test_single_step();
        test_bounce();
        test_async_reset();
        test_bounce_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
